// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the program-counter sequencer.
//   state_e        : sequencer state encoding (also visible on the debug port)
//   CPU_ADDR_W     : PC / branch target width
//   CPU_INS_W      : instruction width
//   CPU_RESET_VEC  : default boot address
package cpu_pkg;

    localparam int CPU_ADDR_W = 24;
    localparam int CPU_INS_W  = 24;
    localparam logic [CPU_ADDR_W-1:0] CPU_RESET_VEC = 24'h000000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BOOT     = 3'd1,
        ST_FETCH    = 3'd2,
        ST_DECODE   = 3'd3,
        ST_EXEC     = 3'd4,
        ST_REDIRECT = 3'd5,
        ST_HALT     = 3'd6
    } state_e;

endpackage

// File: rtl/pc_sequencer_retire_counter.sv
// retire_counter: free-running count of retired instructions.
//   clk, reset : clock, asynchronous active-high reset (clears count)
//   en         : add one this cycle
//   count      : current count, wraps modulo 2^W
module retire_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute controller that owns the program counter's
// write, increment and C-bus inputs.
//   clk, reset        : clock, asynchronous active-high reset
//   start             : begin execution (looked at in IDLE only)
//   imem_req/imem_ack : fetch handshake; imem_req is held for all of FETCH and
//                       the instruction is taken in the cycle imem_ack is high
//   imem_data         : fetched instruction
//   ir, ir_valid      : instruction register, valid in DECODE and EXEC
//   halt_ins          : decoded halt, looked at in DECODE
//   stall, exec_done  : execute handshake; a stall masks exec_done
//   branch_taken      : qualifies exec_done, redirect to branch_target
//   pc_write, pc_inc  : PC controls, never both high
//   pc_c_bus          : value loaded on pc_write, zero otherwise
//   state, busy       : debug state encoding, high outside IDLE/HALT
//   retired           : count of completed instructions
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = CPU_ADDR_W,
    parameter int                INS_W     = CPU_INS_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = CPU_RESET_VEC,
    parameter int                CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [INS_W-1:0]  imem_data,
    output logic [INS_W-1:0]  ir,
    output logic              ir_valid,
    input  logic              halt_ins,
    input  logic              stall,
    input  logic              exec_done,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              pc_write,
    output logic              pc_inc,
    output logic [ADDR_W-1:0] pc_c_bus,
    output logic [2:0]        state,
    output logic              busy,
    output logic [CNT_W-1:0]  retired
);

    state_e            cur_state;
    state_e            nxt_state;
    logic [ADDR_W-1:0] target;
    logic              fetch_hit;
    logic              retire;

    // Qualified handshakes: acks and completions outside their states are ignored.
    assign fetch_hit = (cur_state == ST_FETCH) && imem_ack;
    assign retire    = (cur_state == ST_EXEC) && !stall && exec_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= ST_IDLE;
            ir        <= '0;
            target    <= '0;
        end else begin
            cur_state <= nxt_state;
            if (fetch_hit) begin
                ir <= imem_data;
            end
            if (retire && branch_taken) begin
                target <= branch_target;
            end
        end
    end

    always_comb begin
        nxt_state = cur_state;
        unique case (cur_state)
            ST_IDLE:     if (start) nxt_state = ST_BOOT;
            ST_BOOT:     nxt_state = ST_FETCH;
            ST_FETCH:    if (imem_ack) nxt_state = ST_DECODE;
            ST_DECODE:   nxt_state = halt_ins ? ST_HALT : ST_EXEC;
            ST_EXEC:     if (retire) nxt_state = branch_taken ? ST_REDIRECT : ST_FETCH;
            ST_REDIRECT: nxt_state = ST_FETCH;
            ST_HALT:     nxt_state = ST_HALT;
            default:     nxt_state = ST_IDLE;
        endcase
    end

    // Moore outputs. pc_write and pc_inc come from disjoint states so the
    // PC's increment-over-write priority can never swallow a load.
    always_comb begin
        imem_req = 1'b0;
        ir_valid = 1'b0;
        pc_write = 1'b0;
        pc_inc   = 1'b0;
        pc_c_bus = '0;
        busy     = 1'b1;
        unique case (cur_state)
            ST_IDLE:     busy = 1'b0;
            ST_BOOT:     begin pc_write = 1'b1; pc_c_bus = RESET_VEC; end
            ST_FETCH:    imem_req = 1'b1;
            ST_DECODE:   begin pc_inc = 1'b1; ir_valid = 1'b1; end
            ST_EXEC:     ir_valid = 1'b1;
            ST_REDIRECT: begin pc_write = 1'b1; pc_c_bus = target; end
            ST_HALT:     busy = 1'b0;
            default:     busy = 1'b0;
        endcase
    end

    assign state = cur_state;

    retire_counter #(.W(CNT_W)) u_retire (
        .clk   (clk),
        .reset (reset),
        .en    (retire),
        .count (retired)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. A second instance with a 4-bit retired
// counter shares all stimulus so the wrap case rides along with the main run.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        imem_ack;
    logic [23:0] imem_data;
    logic        halt_ins;
    logic        stall;
    logic        exec_done;
    logic        branch_taken;
    logic [23:0] branch_target;

    logic        imem_req, ir_valid, pc_write, pc_inc, busy;
    logic [23:0] ir, pc_c_bus;
    logic [2:0]  state;
    logic [31:0] retired;

    logic        s_imem_req, s_ir_valid, s_pc_write, s_pc_inc, s_busy;
    logic [23:0] s_ir, s_pc_c_bus;
    logic [2:0]  s_state;
    logic [3:0]  s_retired;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .ir(ir), .ir_valid(ir_valid), .halt_ins(halt_ins), .stall(stall),
        .exec_done(exec_done), .branch_taken(branch_taken),
        .branch_target(branch_target), .pc_write(pc_write), .pc_inc(pc_inc),
        .pc_c_bus(pc_c_bus), .state(state), .busy(busy), .retired(retired)
    );

    pc_sequencer #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(s_imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .ir(s_ir), .ir_valid(s_ir_valid), .halt_ins(halt_ins), .stall(stall),
        .exec_done(exec_done), .branch_taken(branch_taken),
        .branch_target(branch_target), .pc_write(s_pc_write), .pc_inc(s_pc_inc),
        .pc_c_bus(s_pc_c_bus), .state(s_state), .busy(s_busy), .retired(s_retired)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full control-output picture for one state.
    task automatic check_ctl(input string tag, input logic [2:0] st, input logic req,
                             input logic inc, input logic wr, input logic [23:0] cbus,
                             input logic irv, input logic bsy);
        check({tag, ".state"},    32'(state),    32'(st));
        check({tag, ".imem_req"}, 32'(imem_req), 32'(req));
        check({tag, ".pc_inc"},   32'(pc_inc),   32'(inc));
        check({tag, ".pc_write"}, 32'(pc_write), 32'(wr));
        check({tag, ".pc_c_bus"}, 32'(pc_c_bus), 32'(cbus));
        check({tag, ".ir_valid"}, 32'(ir_valid), 32'(irv));
        check({tag, ".busy"},     32'(busy),     32'(bsy));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_data = '0;
        halt_ins = 1'b0; stall = 1'b0; exec_done = 1'b0; branch_taken = 1'b0;
        branch_target = '0;
        tick(); tick();

        // Reset state
        check_ctl("rst", 3'd0, 0, 0, 0, 24'h0, 0, 0);
        check("rst.ir", 32'(ir), 32'h0);
        check("rst.retired", retired, 32'h0);
        reset = 1'b0;
        tick();
        check("idle_hold.state", 32'(state), 32'd0);

        // Boot
        start = 1'b1;
        tick();
        check_ctl("boot", 3'd1, 0, 0, 1, 24'h000000, 0, 1);
        start = 1'b0;
        tick();
        check_ctl("fetch0", 3'd2, 1, 0, 0, 24'h0, 0, 1);

        // Fetch wait: ack withheld five cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("fetch_wait.state", 32'(state), 32'd2);
            check("fetch_wait.imem_req", 32'(imem_req), 32'd1);
        end
        imem_ack = 1'b1; imem_data = 24'hABCDEF;
        tick();
        imem_ack = 1'b0; imem_data = 24'h0;
        check_ctl("decode", 3'd3, 0, 1, 0, 24'h0, 1, 1);
        check("decode.ir", 32'(ir), 32'hABCDEF);
        tick();
        check_ctl("exec", 3'd4, 0, 0, 0, 24'h0, 1, 1);
        check("exec.ir", 32'(ir), 32'hABCDEF);

        // Branch
        exec_done = 1'b1; branch_taken = 1'b1; branch_target = 24'h00F0A0;
        tick();
        exec_done = 1'b0; branch_taken = 1'b0; branch_target = 24'h0;
        check_ctl("redirect", 3'd5, 0, 0, 1, 24'h00F0A0, 0, 1);
        check("redirect.retired", retired, 32'd1);
        tick();
        check_ctl("post_redirect", 3'd2, 1, 0, 0, 24'h0, 0, 1);
        check("post_redirect.retired", retired, 32'd1);

        // Zero-wait fetch into EXEC
        imem_ack = 1'b1; imem_data = 24'h123456;
        tick();
        imem_ack = 1'b0;
        check("fetch2.ir", 32'(ir), 32'h123456);
        tick();
        check("exec2.state", 32'(state), 32'd4);

        // Stall masks exec_done
        stall = 1'b1; exec_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall.state", 32'(state), 32'd4);
            check("stall.retired", retired, 32'd1);
        end
        stall = 1'b0;
        tick();
        exec_done = 1'b0;
        check("unstall.state", 32'(state), 32'd2);
        check("unstall.retired", retired, 32'd2);

        // Fifteen more straight-line instructions: 17 total
        for (int i = 0; i < 15; i++) begin
            imem_ack = 1'b1; imem_data = 24'(i + 1);
            tick();
            imem_ack = 1'b0;
            tick();
            exec_done = 1'b1;
            tick();
            exec_done = 1'b0;
            check("loop.state", 32'(state), 32'd2);
        end
        check("wrap.retired32", retired, 32'd17);
        check("wrap.retired4", 32'(s_retired), 32'd1);

        // Halt
        imem_ack = 1'b1; imem_data = 24'h00FFFF;
        tick();
        imem_ack = 1'b0;
        check("halt_decode.pc_inc", 32'(pc_inc), 32'd1);
        halt_ins = 1'b1;
        tick();
        halt_ins = 1'b0;
        check_ctl("halt", 3'd6, 0, 0, 0, 24'h0, 0, 0);
        start = 1'b1;
        tick(); tick();
        start = 1'b0;
        check("halt_start.state", 32'(state), 32'd6);

        // Reset mid-HALT acts without waiting for a clock edge
        reset = 1'b1;
        #1;
        check_ctl("halt_rst", 3'd0, 0, 0, 0, 24'h0, 0, 0);
        check("halt_rst.retired", retired, 32'd0);
        check("halt_rst.ir", 32'(ir), 32'h0);
        tick();
        reset = 1'b0;

        // Reset mid-FETCH with a coincident ack
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("fetch3.state", 32'(state), 32'd2);
        imem_ack = 1'b1; imem_data = 24'h555555; reset = 1'b1;
        tick();
        imem_ack = 1'b0; reset = 1'b0;
        check("fetch_rst.ir", 32'(ir), 32'h0);
        check("fetch_rst.state", 32'(state), 32'd0);
        tick();
        check("fetch_rst_idle.state", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard bound on run length.
    initial begin
        #100000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
